// File: rtl/inv_pkg.sv
// Shared types, constants and the saturating quantity arithmetic used by
// the inventory transaction controller.
package inv_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int QTY_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WRITE,
    RESP
  } state_t;

  localparam logic OP_ADD    = 1'b1;
  localparam logic OP_REMOVE = 1'b0;

  localparam logic [QTY_W_DEF-1:0] QTY_MAX = 8'hFF;

  typedef struct packed {
    logic                 sat;
    logic [QTY_W_DEF-1:0] value;
  } calc_t;

  // Sized at QTY_W_DEF; a controller built with a different QTY_W needs a matching package.
  function automatic calc_t sat_apply(input logic op,
                                      input logic [QTY_W_DEF-1:0] rdata,
                                      input logic [QTY_W_DEF-1:0] qty);
    calc_t          res;
    logic [QTY_W_DEF:0] sum;
    res = '0;
    sum = {1'b0, rdata} + {1'b0, qty};
    if (op == OP_ADD) begin
      if (sum > {1'b0, QTY_MAX}) begin
        res.sat   = 1'b1;
        res.value = QTY_MAX;
      end else begin
        res.value = sum[QTY_W_DEF-1:0];
      end
    end else if (qty > rdata) begin
      res.sat   = 1'b1;
      res.value = '0;
    end else begin
      res.value = rdata - qty;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant starts at 1 so requester 0 wins
// the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic last_q;

  always_comb begin
    grant = req;
    if (&req) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (|grant)) begin
      last_q <= grant[1];
    end
  end

  assign last_grant = last_q;

endmodule

// File: rtl/inv_txn_ctrl.sv
// Read-modify-write sequencer for the inventory quantity memory, shared by
// the front panel (requester 0) and the serial host (requester 1).
module inv_txn_ctrl
  import inv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int QTY_W  = QTY_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_op,
  input  logic [2*ADDR_W-1:0] req_code,
  input  logic [2*QTY_W-1:0]  req_qty,
  output logic [1:0]          req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [QTY_W-1:0]    mem_wdata,
  input  logic [QTY_W-1:0]    mem_rdata,
  output logic                done_valid,
  output logic                done_id,
  output logic [QTY_W-1:0]    done_qty,
  output logic                done_sat,
  output logic                busy
);

  state_t             state_q, state_d;
  logic [1:0]         ready_q, ready_d;
  logic [1:0]         grant;
  logic               arb_adv;
  logic               last_grant;
  logic               op_q;
  logic               id_q;
  logic               sat_q;
  logic [ADDR_W-1:0]  code_q;
  logic [QTY_W-1:0]   qty_q;
  logic [QTY_W-1:0]   wdata_q;
  calc_t              res;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .advance    (arb_adv),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // The grant is registered into ready_q so req_ready never sees req_valid combinationally;
  // the decision is made in IDLE (or RESP, to keep 5-cycle throughput) and the pulse lands in IDLE.
  always_comb begin
    state_d = state_q;
    ready_d = 2'b00;
    arb_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready_q != 2'b00) begin
          state_d = READ;
        end else if (|req_valid) begin
          ready_d = grant;
          arb_adv = 1'b1;
        end
      end
      READ:  state_d = CALC;
      CALC:  state_d = WRITE;
      WRITE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (|req_valid) begin
          ready_d = grant;
          arb_adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res = sat_apply(op_q, mem_rdata, qty_q);

  // last_grant already names the requester whose ready pulse is showing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 2'b00;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      code_q  <= '0;
      qty_q   <= '0;
      wdata_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if ((state_q == IDLE) && (ready_q != 2'b00)) begin
        id_q   <= last_grant;
        op_q   <= req_op[last_grant];
        code_q <= last_grant ? req_code[2*ADDR_W-1:ADDR_W] : req_code[ADDR_W-1:0];
        qty_q  <= last_grant ? req_qty[2*QTY_W-1:QTY_W] : req_qty[QTY_W-1:0];
      end
      if (state_q == CALC) begin
        wdata_q <= res.value;
        sat_q   <= res.sat;
      end
    end
  end

  assign req_ready  = ready_q;
  assign mem_addr   = code_q;
  assign mem_we     = (state_q == WRITE);
  assign mem_wdata  = wdata_q;
  assign done_valid = (state_q == RESP);
  assign done_id    = id_q;
  assign done_qty   = wdata_q;
  assign done_sat   = sat_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_inv_txn_ctrl.sv
// Directed bench for inv_txn_ctrl with a behavioural synchronous memory and
// a scoreboard of expected writes/completions.
module tb_inv_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_code;
  logic [15:0] req_qty;
  logic [1:0]  req_ready;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        done_valid;
  logic        done_id;
  logic [7:0]  done_qty;
  logic        done_sat;
  logic        busy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic       id;
    logic [7:0] addr;
    logic [7:0] qty;
    logic       sat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] tb_mem [256];
  logic [7:0] model  [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  inv_txn_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_code   (req_code),
    .req_qty    (req_qty),
    .req_ready  (req_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_qty   (done_qty),
    .done_sat   (done_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_addr] <= pre_data;
    else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_calc(input logic op, input logic [7:0] r, input logic [7:0] q);
    int s;
    if (op) begin
      s = int'(r) + int'(q);
      return (s > 255) ? {1'b1, 8'hFF} : {1'b0, 8'(s)};
    end
    return (q > r) ? {1'b1, 8'h00} : {1'b0, 8'(r - q)};
  endfunction

  // Scoreboard consumer: every write and completion must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (sb.size() == 0) check("unexpected_write", 32'(mem_we), 32'd0);
        else begin
          check("wr_addr", 32'(mem_addr), 32'(sb[0].addr));
          check("wr_data", 32'(mem_wdata), 32'(sb[0].qty));
        end
      end
      if (done_valid) begin
        if (sb.size() == 0) check("unexpected_done", 32'(done_valid), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("done_id", 32'(done_id), 32'(e.id));
          check("done_qty", 32'(done_qty), 32'(e.qty));
          check("done_sat", 32'(done_sat), 32'(e.sat));
          done_cnt++;
          $display("txn done: id=%0d addr=%02h qty=%0d sat=%0d", done_id, e.addr, done_qty, done_sat);
        end
      end
    end
  end

  task automatic drive(input int id, input logic op, input logic [7:0] code,
                       input logic [7:0] qty, input bit expect_done);
    logic [8:0] r;
    if (expect_done) begin
      r = ref_calc(op, model[code], qty);
      model[code] = r[7:0];
      sb.push_back('{id[0], code, r[7:0], r[8]});
    end
    req_op[id]          = op;
    req_code[id*8 +: 8] = code;
    req_qty[id*8 +: 8]  = qty;
    req_valid[id]       = 1'b1;
  endtask

  task automatic wait_ready(input int id, output int at);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
    end
    at = cyc;
    check($sformatf("ready_id%0d", id), 32'(req_ready), 32'(2'b01 << id));
  endtask

  task automatic release_req(input int id);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic issue(input int id, input logic op, input logic [7:0] code,
                       input logic [7:0] qty, output int at);
    drive(id, op, code, qty, 1'b1);
    wait_ready(id, at);
    release_req(id);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, d0;
    logic [7:0] v;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = 2'b00;
    req_code  = '0;
    req_qty   = '0;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = 8'd0;
      case (i)
        'h12: v = 8'd100;
        'h05: v = 8'd200;
        'h07: v = 8'd10;
        'h30: v = 8'd77;
        default: v = 8'd0;
      endcase
      pre_we   = 1'b1;
      pre_addr = 8'(i);
      pre_data = v;
      model[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;

    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_done_qty", 32'(done_qty), 32'd0);
    check("rst_done_sat", 32'(done_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Both requesters valid out of reset: panel first, host five cycles later.
    drive(0, 1'b1, 8'h40, 8'd3, 1'b1);
    drive(1, 1'b1, 8'h41, 8'd4, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, c0);
    release_req(0);
    wait_ready(1, c1);
    check("rr_spacing", 32'(c1 - c0), 32'd5);
    release_req(1);
    drive(0, 1'b1, 8'h40, 8'd1, 1'b1);
    drive(1, 1'b1, 8'h41, 8'd2, 1'b1);
    wait_ready(0, c0);
    release_req(0);
    wait_ready(1, c1);
    release_req(1);
    wait_idle();

    // Cycle-exact latency of a single accept.
    issue(0, 1'b1, 8'h12, 8'd50, c0);
    @(negedge clk);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("lat_c2_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("lat_c3_we", 32'(mem_we), 32'd1);
    check("lat_c3_addr", 32'(mem_addr), 32'h12);
    check("lat_c3_wdata", 32'(mem_wdata), 32'd150);
    @(negedge clk);
    check("lat_c4_done", 32'(done_valid), 32'd1);
    check("lat_c4_qty", 32'(done_qty), 32'd150);
    check("lat_c4_sat", 32'(done_sat), 32'd0);
    @(negedge clk);
    check("lat_c5_busy", 32'(busy), 32'd0);
    wait_idle();

    issue(1, 1'b1, 8'h05, 8'd100, c0);
    wait_idle();
    check("mem05_sat", 32'(tb_mem[8'h05]), 32'd255);
    issue(0, 1'b0, 8'h05, 8'd30, c0);
    wait_idle();
    check("mem05_rem", 32'(tb_mem[8'h05]), 32'd225);

    issue(0, 1'b0, 8'h07, 8'd25, c0);
    wait_idle();
    issue(1, 1'b0, 8'h07, 8'd0, c0);
    wait_idle();
    check("mem07", 32'(tb_mem[8'h07]), 32'd0);

    // Host request raised while busy on the same code.
    d0 = done_cnt;
    issue(0, 1'b1, 8'h20, 8'd10, c0);
    drive(1, 1'b1, 8'h20, 8'd20, 1'b1);
    wait_ready(1, c1);
    release_req(1);
    wait_idle();
    check("mem20", 32'(tb_mem[8'h20]), 32'd30);
    check("mem20_dones", 32'(done_cnt - d0), 32'd2);

    // Reset during CALC: the transaction is dropped.
    drive(0, 1'b1, 8'h30, 8'd5, 1'b0);
    wait_ready(0, c0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done_valid), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_we_hold", 32'(mem_we), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("mem30_kept", 32'(tb_mem[8'h30]), 32'd77);
    issue(0, 1'b0, 8'h30, 8'd7, c0);
    wait_idle();
    check("mem30_after", 32'(tb_mem[8'h30]), 32'd70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
